// File: rtl/elevator_call_ctrl_if.sv
// Signal bundle between elevator_call_ctrl and its environment: raw buttons and
// car position in, latched calls, door status and door FSM state out.
interface elevator_call_ctrl_if;
  logic [3:0] hall_btn;
  logic [3:0] car_btn;
  logic [1:0] current_floor;
  logic       car_stopped;
  logic [3:0] buttons_out;
  logic [3:0] buttons_in;
  logic       door_open;
  logic       door_state;

  // Level-only signals, no valid/ready handshake: calls stay pending until
  // the door dwell at their floor completes.
  modport master (
    output hall_btn, car_btn, current_floor, car_stopped,
    input  buttons_out, buttons_in, door_open, door_state
  );

  modport slave (
    input  hall_btn, car_btn, current_floor, car_stopped,
    output buttons_out, buttons_in, door_open, door_state
  );
endinterface

// File: rtl/elevator_call_ctrl.sv
// Hall/car call latching with synchronized, debounced buttons and a door dwell FSM.
// Optional macro CAR_CALL_CANCEL_EN: a second car press on a pending call cancels it.
module elevator_call_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_call_ctrl_if.slave  bus
);

  localparam int         NB      = 8;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DW_LAST = 8'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } door_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] level;
  logic [NB-1:0] level_q;
  logic [NB-1:0] evt;
  logic [7:0]    db_cnt [NB];

  door_state_e   state_q;
  door_state_e   state_nxt;
  logic [7:0]    dwell_cnt;
  logic [7:0]    dwell_cnt_nxt;
  logic          door_q;
  logic          door_nxt;
  logic [3:0]    bout_q;
  logic [3:0]    bin_q;
  logic [3:0]    bout_nxt;
  logic [3:0]    bin_nxt;

  logic [3:0]    cf_mask;
  logic [3:0]    sup_mask;
  logic [3:0]    hall_evt;
  logic [3:0]    car_evt;
  logic [3:0]    clr_mask;
  logic          at_floor_evt;
  logic          dwell_done;
`ifdef CAR_CALL_CANCEL_EN
  logic [3:0]    in_cancel;
`endif

  assign raw = {bus.car_btn, bus.hall_btn};

  // Two-flop synchronizers for all eight raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sync2[b] != level[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            level[b]  <= sync2[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + 8'd1;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect of the debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      evt     <= '0;
    end else begin
      level_q <= level;
      evt     <= level & ~level_q;
    end
  end

  assign cf_mask    = 4'b0001 << bus.current_floor;
  assign dwell_done = (state_q == DWELL) && (dwell_cnt == DW_LAST);

  // Door FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Door FSM: next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (bus.car_stopped && |(cf_mask & (bin_q | bout_q))) state_nxt = DWELL;
      end
      DWELL: begin
        if (!bus.car_stopped || dwell_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Door FSM: outputs and call bookkeeping. During a dwell, presses at the
  // current floor only restart the timer; the terminal clear beats any press.
  always_comb begin
    sup_mask      = (state_q == DWELL) ? cf_mask : 4'b0000;
    hall_evt      = evt[3:0] & ~sup_mask;
    car_evt       = evt[7:4] & ~sup_mask;
    at_floor_evt  = |((evt[3:0] | evt[7:4]) & cf_mask);
    clr_mask      = (bus.car_stopped && dwell_done) ? cf_mask : 4'b0000;
    door_nxt      = (state_nxt == DWELL);
    dwell_cnt_nxt = 8'd0;
    if (state_q == DWELL && state_nxt == DWELL && !at_floor_evt) begin
      dwell_cnt_nxt = dwell_cnt + 8'd1;
    end
    bout_nxt = (bout_q | hall_evt) & ~clr_mask;
`ifdef CAR_CALL_CANCEL_EN
    in_cancel = car_evt & bin_q;
    bin_nxt   = ((bin_q | (car_evt & ~in_cancel)) & ~in_cancel) & ~clr_mask;
`else
    bin_nxt   = (bin_q | car_evt) & ~clr_mask;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      door_q    <= 1'b0;
      bout_q    <= '0;
      bin_q     <= '0;
    end else begin
      dwell_cnt <= dwell_cnt_nxt;
      door_q    <= door_nxt;
      bout_q    <= bout_nxt;
      bin_q     <= bin_nxt;
    end
  end

  assign bus.buttons_out = bout_q;
  assign bus.buttons_in  = bin_q;
  assign bus.door_open   = door_q;
  assign bus.door_state  = state_q;

endmodule

// File: doc/elevator_call_ctrl.md
ELEVATOR_CALL_CTRL -- requirements
Module: elevator_call_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a button level change (range 1-255).
REQ-002 Parameter DWELL_CYCLES, default 8, door-open dwell length in clock cycles (range 1-255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 hall_btn  input  4  raw asynchronous hall call buttons, bit f = floor f.
REQ-006 car_btn  input  4  raw asynchronous car-panel buttons, bit f = floor f.
REQ-007 current_floor  input  2  floor the car is at, from position sensing.
REQ-008 car_stopped  input  1  1 = car stationary (downstream dir_up and dir_down both 0).
REQ-009 buttons_out  output  4  latched pending hall calls, fed to the elevator controller.
REQ-010 buttons_in  output  4  latched pending car calls, fed to the elevator controller.
REQ-011 door_open  output  1  1 while door dwell in progress.

Function
REQ-012 Each of the 8 raw buttons SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Per button: debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any mismatch-free gap resets that button's counter.
REQ-014 Press event = 0->1 transition of a debounced level; 1->0 transitions produce no event.
REQ-015 Latency: raw input held high from edge k SHALL set its pending bit on edge k+DEBOUNCE_CYCLES+3 (7 with defaults), absent a clear.
REQ-016 Press event on floor f sets buttons_out[f] (hall) or buttons_in[f] (car); already-set bit stays set; multiple events same cycle all take effect.
REQ-017 Door FSM states: IDLE, DWELL.
REQ-018 IDLE->DWELL when car_stopped=1 and (buttons_in|buttons_out)[current_floor]=1; dwell counter loads 0; door_open=1 from the next cycle.
REQ-019 DWELL: counter increments each cycle; on reaching DWELL_CYCLES-1, buttons_in[current_floor] and buttons_out[current_floor] clear together, FSM -> IDLE, door_open -> 0 next cycle.
REQ-020 DWELL: press event at current_floor SHALL restart counter to 0 and SHALL NOT set a pending bit.
REQ-021 DWELL: car_stopped=0 aborts to IDLE with no bits cleared.
REQ-022 Clear and press event on the same floor in the same cycle: clear wins; events at other floors unaffected.
REQ-023 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-024 While reset=0: buttons_in=0000, buttons_out=0000, door_open=0, FSM=IDLE, all synchronizer, debounce and dwell state = 0.
REQ-025 Reset asserted mid-dwell or mid-debounce discards all pending calls and partial counts; after release a still-held button SHALL re-register only after full latency (REQ-015).

Configuration
REQ-026 Macro CAR_CALL_CANCEL_EN: when defined, a car press event on floor f with buttons_in[f]=1 and f != current_floor or FSM=IDLE SHALL clear buttons_in[f] (toggle cancel); hall calls unaffected.
REQ-027 Without CAR_CALL_CANCEL_EN, a press on an already-pending car call is ignored; no cancel logic is synthesized.

Verification
REQ-028 Defaults, reset release, car_btn[2] high 20 cycles from edge 10 -> buttons_in=0100 on edge 17, stays set.
REQ-029 hall_btn[1] glitch high 3 cycles -> buttons_out unchanged 0000 (below DEBOUNCE_CYCLES).
REQ-030 buttons_out=1000 pending, current_floor=3, car_stopped=1 -> door_open=1 for 8 cycles, then buttons_out=0000, door_open=0.
REQ-031 During dwell at floor 3, car_btn[3] press event at dwell count 5 -> dwell restarts, door_open high 14 cycles total, buttons_in[3] never set.
REQ-032 reset=0 asserted mid-dwell with buttons_in=0110 -> all outputs 0 immediately (asynchronous), FSM IDLE after release.
REQ-033 With CAR_CALL_CANCEL_EN, car_btn[1] pressed twice while car at floor 0 -> buttons_in[1] goes 1 then 0; without macro, stays 1.
